// File: rtl/gerador_paridade_pkg.sv
`default_nettype none
// ============================================================================
// Module : gerador_paridade_pkg
// Brief  : Shared parity constants and helper function.
// Rev    : 1.0  initial release
// ============================================================================
package gerador_paridade_pkg;

  localparam int PARIDADE_IMPAR = 1;
  localparam int PARIDADE_PAR   = 0;
  localparam int MAX_WIDTH      = 64;

  // Zero-extension does not change parity, so narrower words can be passed in.
  function automatic logic calc_paridade(input logic [MAX_WIDTH-1:0] word,
                                         input logic                 odd);
    return (^word) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gerador_paridade_arvore.sv
`default_nettype none
// ============================================================================
// Module : paridade_arvore
// Brief  : Combinational WIDTH-bit XOR reduction tree with odd/even invert.
// Rev    : 1.0  initial release
// ============================================================================
module paridade_arvore #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b1
) (
  input  logic [WIDTH-1:0] i_dados,
  output logic             o_paridade
);

  localparam int c_LEVELS = $clog2(WIDTH);
  localparam int c_LEAVES = 1 << c_LEVELS;

  // Level 0 holds the leaves padded with zeros to a power of two.
  for (genvar l = 0; l <= c_LEVELS; l++) begin : g_lvl
    logic [(c_LEAVES >> l)-1:0] w_v;
    if (l == 0) begin : g_folha
      for (genvar k = 0; k < c_LEAVES; k++) begin : g_leaf
        if (k < WIDTH) begin : g_bit
          assign w_v[k] = i_dados[k];
        end else begin : g_pad
          assign w_v[k] = 1'b0;
        end
      end
    end else begin : g_no
      for (genvar k = 0; k < (c_LEAVES >> l); k++) begin : g_xor
        assign w_v[k] = g_lvl[l-1].w_v[2*k] ^ g_lvl[l-1].w_v[2*k+1];
      end
    end
  end

  assign o_paridade = g_lvl[c_LEVELS].w_v[0] ^ ODD;

endmodule
`default_nettype wire

// File: rtl/gerador_paridade.sv
`default_nettype none
// ============================================================================
// Module : gerador_paridade
// Brief  : Registered parity generator; optional checker via
//          GERADOR_PARIDADE_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module gerador_paridade
  import gerador_paridade_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ODD   = PARIDADE_IMPAR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dados_valid,
`ifdef GERADOR_PARIDADE_CHECK_EN
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_dados,
  input  logic             rx_paridade,
  output logic             erro_paridade,
  output logic             erro_valid,
`endif
  input  logic [WIDTH-1:0] dados,
  output logic [WIDTH-1:0] dados_out,
  output logic             paridade,
  output logic             paridade_valid
);

  localparam bit   c_ODD       = (ODD != PARIDADE_PAR);
  localparam logic c_PAR_RESET = calc_paridade('0, c_ODD);

  logic             w_paridade_tx;
  logic [WIDTH-1:0] r_dados_out;
  logic             r_paridade;
  logic             r_valid;

  paridade_arvore #(.WIDTH(WIDTH), .ODD(c_ODD)) u_arvore_tx (
    .i_dados    (dados),
    .o_paridade (w_paridade_tx)
  );

  // Data/parity load only on valid words, so idle-cycle inputs never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dados_out <= '0;
      r_paridade  <= c_PAR_RESET;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= dados_valid;
      if (dados_valid) begin
        r_dados_out <= dados;
        r_paridade  <= w_paridade_tx;
      end
    end
  end

  assign dados_out      = r_dados_out;
  assign paridade       = r_paridade;
  assign paridade_valid = r_valid;

`ifdef GERADOR_PARIDADE_CHECK_EN
  logic w_paridade_rx;
  logic r_erro;
  logic r_erro_valid;

  paridade_arvore #(.WIDTH(WIDTH), .ODD(c_ODD)) u_arvore_rx (
    .i_dados    (rx_dados),
    .o_paridade (w_paridade_rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_erro       <= 1'b0;
      r_erro_valid <= 1'b0;
    end else begin
      r_erro_valid <= rx_valid;
      if (rx_valid) begin
        r_erro <= w_paridade_rx ^ rx_paridade;
      end
    end
  end

  assign erro_paridade = r_erro;
  assign erro_valid    = r_erro_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gerador_paridade.sv
`default_nettype none
// ============================================================================
// Module : tb_gerador_paridade
// Brief  : Self-checking bench for gerador_paridade (ODD=1 and ODD=0).
// Rev    : 1.0  initial release
// ============================================================================
module tb_gerador_paridade;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dados_valid = 1'b0;
  logic [7:0] dados = 8'h00;
  logic [7:0] dados_out, dados_out0;
  logic       paridade, paridade0, pvalid, pvalid0;
`ifdef GERADOR_PARIDADE_CHECK_EN
  logic       rx_valid = 1'b0;
  logic [7:0] rx_dados = 8'h00;
  logic       rx_paridade = 1'b0;
  logic       erro_paridade, erro_valid, erro_paridade0, erro_valid0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_dados;
  logic       m_par, m_par0, m_valid;
`ifdef GERADOR_PARIDADE_CHECK_EN
  logic       m_erro, m_evalid;
`endif

  always #5 clk = ~clk;

  gerador_paridade #(.WIDTH(8), .ODD(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .dados_valid(dados_valid),
`ifdef GERADOR_PARIDADE_CHECK_EN
    .rx_valid(rx_valid), .rx_dados(rx_dados), .rx_paridade(rx_paridade),
    .erro_paridade(erro_paridade), .erro_valid(erro_valid),
`endif
    .dados(dados), .dados_out(dados_out), .paridade(paridade),
    .paridade_valid(pvalid)
  );

  gerador_paridade #(.WIDTH(8), .ODD(0)) u_dut_par (
    .clk(clk), .rst_n(rst_n), .dados_valid(dados_valid),
`ifdef GERADOR_PARIDADE_CHECK_EN
    .rx_valid(rx_valid), .rx_dados(rx_dados), .rx_paridade(rx_paridade),
    .erro_paridade(erro_paridade0), .erro_valid(erro_valid0),
`endif
    .dados(dados), .dados_out(dados_out0), .paridade(paridade0),
    .paridade_valid(pvalid0)
  );

  // Parity from a count of ones: odd mode wants the total count odd.
  function automatic logic ref_par(input logic [7:0] d, input bit odd);
    int cnt;
    cnt = $countones(d);
    return odd ? ((cnt % 2) == 0) : ((cnt % 2) == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus just after a falling edge; return at the next one.
  task automatic cycle(input logic v, input logic [7:0] d);
    dados_valid = v;
    dados       = d;
    @(negedge clk);
    m_valid = v;
    if (v) begin
      m_dados = d;
      m_par   = ref_par(d, 1'b1);
      m_par0  = ref_par(d, 1'b0);
    end
  endtask

  task automatic reset_model();
    m_dados = 8'h00; m_par = 1'b1; m_par0 = 1'b0; m_valid = 1'b0;
`ifdef GERADOR_PARIDADE_CHECK_EN
    m_erro = 1'b0; m_evalid = 1'b0;
`endif
  endtask

  logic [7:0] sweep_d [9] = '{8'h00, 8'h10, 8'h81, 8'h07, 8'h33, 8'h1F, 8'hBE, 8'hFE, 8'hFF};
  logic       sweep_p [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero word, then assert reset mid-cycle and check immediately.
    cycle(1'b1, 8'hFE);
    chk("pre_rst_dados", dados_out, 8'hFE);
    #2 rst_n = 1'b0;
    dados_valid = 1'b0;
    #1;
    chk("rst_valid", pvalid, 0);
    chk("rst_dados", dados_out, 8'h00);
    chk("rst_par", paridade, 1);
    chk("rst_par_even", paridade0, 0);
`ifdef GERADOR_PARIDADE_CHECK_EN
    chk("rst_erro", erro_paridade, 0);
    chk("rst_evalid", erro_valid, 0);
`endif
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back sweep against the documented parity table.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, sweep_d[i]);
      chk("sweep_valid", pvalid, 1);
      chk("sweep_dados", dados_out, sweep_d[i]);
      chk("sweep_par", paridade, sweep_p[i]);
    end

    // Valid gating: idle cycle with X on the bus must hold the last word.
    cycle(1'b1, 8'h07);
    chk("even_07", paridade0, 1);
    cycle(1'b0, 8'hxx);
    chk("gate_valid", pvalid, 0);
    chk("gate_dados", dados_out, 8'h07);
    chk("gate_par", paridade, 0);
    cycle(1'b1, 8'hFF);
    chk("even_FF", paridade0, 0);

`ifdef GERADOR_PARIDADE_CHECK_EN
    rx_valid = 1'b1; rx_dados = 8'h33; rx_paridade = 1'b1;
    @(negedge clk);
    chk("chk_ok_valid", erro_valid, 1);
    chk("chk_ok_erro", erro_paridade, 0);
    rx_paridade = 1'b0;
    @(negedge clk);
    chk("chk_bad_valid", erro_valid, 1);
    chk("chk_bad_erro", erro_paridade, 1);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("chk_idle_valid", erro_valid, 0);
    chk("chk_hold_erro", erro_paridade, 1);
    m_erro = 1'b1; m_evalid = 1'b0;
`endif

    // Randomized traffic checked against the model.
    for (int i = 0; i < 60; i++) begin
      logic       v;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
`ifdef GERADOR_PARIDADE_CHECK_EN
      rx_valid    = ($urandom_range(0, 1) == 1);
      rx_dados    = 8'($urandom);
      rx_paridade = 1'($urandom);
      if (rx_valid) m_erro = (ref_par(rx_dados, 1'b1) != rx_paridade);
      m_evalid = rx_valid;
`endif
      cycle(v, d);
      chk("rnd_valid", pvalid, m_valid);
      chk("rnd_dados", dados_out, m_dados);
      chk("rnd_par", paridade, m_par);
      chk("rnd_par_even", paridade0, m_par0);
      chk("rnd_valid_even", pvalid0, m_valid);
`ifdef GERADOR_PARIDADE_CHECK_EN
      chk("rnd_evalid", erro_valid, m_evalid);
      chk("rnd_erro", erro_paridade, m_erro);
`endif
    end
`ifdef GERADOR_PARIDADE_CHECK_EN
    rx_valid = 1'b0;
`endif

    // Reset while 0x81 is in flight: it is captured, then wiped before it is seen.
    dados_valid = 1'b1;
    dados       = 8'h81;
    @(posedge clk);
    #2 rst_n = 1'b0;
    dados_valid = 1'b0;
    #1;
    chk("mid_rst_valid", pvalid, 0);
    chk("mid_rst_dados", dados_out, 8'h00);
    chk("mid_rst_par", paridade, 1);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h81);
    chk("post_rst_valid", pvalid, 0);
    chk("post_rst_dados", dados_out, 8'h00);
    cycle(1'b1, 8'h81);
    chk("first_valid", pvalid, 1);
    chk("first_dados", dados_out, 8'h81);
    chk("first_par", paridade, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
